axi_cro_s00_axi_slave: RTL and testbench
========================================

Name: axi_cro_s00_axi_slave

Overview:
AXI4-Lite responder terminating the S00_AXI port of the AXI_CRO peripheral. It holds four 32-bit read/write configuration registers for the ring-oscillator core. Registers are exposed as parallel outputs, and a per-register one-cycle write strobe flags each update. It is the target that the master VIP drives with sequential single-beat writes and read-backs.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers decoded from addr[3:2].

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response, always 2'b00 (OKAY)
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response, always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
slv_reg0..slv_reg3  out  32 each  current register contents
reg_wr_pulse  out  4  bit n high for exactly one cycle after slv_regn is written

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (s00_axi_aclk, s00_axi_aresetn).
- Reset values:
  - all slv_reg = 0, reg_wr_pulse = 0.
  - bvalid = 0, rvalid = 0, rdata = 0, bresp = rresp = 0.
  - awready = wready = arready = 0 during reset.
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle.
  - Each channel has a one-entry holding register.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid. Both are registered and high in the first cycle after reset release.
  - Commit occurs in the cycle where both address and data are available (held or handshaking this cycle) and bvalid = 0.
  - On commit:
    - the register at addr[3:2] is updated per byte lane where wstrb[k] = 1;
    - the matching reg_wr_pulse bit is high next cycle;
    - bvalid rises next cycle and both holds clear.
  - bvalid stays high until the bvalid && bready handshake. No new AW/W is accepted while bvalid is high.
  - wstrb = 0 still completes with OKAY; the register is unchanged but the pulse still fires.
  - Minimum latency: AW+W in cycle t, bvalid in t+1. Back-to-back writes every 2 cycles when bready is tied high.
- Read path:
  - arready = !rvalid.
  - On the AR handshake in cycle t:
    - rdata is loaded from the register at araddr[3:2] with its value at cycle t (pre-write if a commit to the same register occurs in t);
    - rvalid rises at t+1.
  - rvalid and rdata stay stable until rready; arready returns high the cycle after the R handshake.
  - Throughput: one read per 2 cycles.
- Arbitration: reads and writes are fully independent and may complete in the same cycle.
- Addressing: addr[1:0] is ignored (unaligned access maps to the containing word). No SLVERR/DECERR is ever generated.
- Mid-transaction reset: asserting aresetn low at any time immediately clears holds, valids and registers. No pending response survives.

Test Plan:
- Sequential writes 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC (wstrb = 0xF), then reads of the same addresses → rdata 0x1,0x2,0x3,0x4, all bresp/rresp = OKAY, each bvalid exactly 1 cycle after commit.
- W presented 3 cycles before AW (data 0xDEADBEEF to 0x8) → wready drops after the W handshake, no bvalid until AW arrives; slv_reg2 = 0xDEADBEEF, reg_wr_pulse = 4'b0100 for one cycle.
- Byte strobes: slv_reg1 = 0xFFFFFFFF, then write 0x12345678 with wstrb = 4'b0101 → readback 0xFF34FF78.
- Backpressure: bready held low 10 cycles after a write → bvalid stays high, awready/wready stay low, and a second AW is not accepted until the B handshake. rready held low 5 cycles → rdata stable, arready low.
- Same-cycle read and write of 0x0 (old value 0xA, new value 0xB) → read returns 0xA, and a subsequent read returns 0xB.
- aresetn pulsed low while bvalid = 1 and slv_reg3 = 0x55 → bvalid = 0 and slv_reg3 = 0 asynchronously. After release, awready/wready/arready are high on the first clock and a new write completes normally.

Source files
------------

// File: rtl/axi_cro_s00_axi_slave.sv
// AXI4-Lite responder for the AXI_CRO S00_AXI port: four 32-bit configuration registers
// with parallel outputs and a one-cycle write strobe per register.
module axi_cro_s00_axi_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
   output logic [3:0]                      reg_wr_pulse
);

   localparam int unsigned NumBytes = C_S_AXI_DATA_WIDTH / 8;

   logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
   logic [3:0]                         pulse_q, pulse_d;
   logic                               aw_held_q, aw_held_d;
   logic [1:0]                         aw_idx_q, aw_idx_d;
   logic                               w_held_q, w_held_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]      w_data_q, w_data_d;
   logic [NumBytes-1:0]                w_strb_q, w_strb_d;
   logic                               awready_q, awready_d;
   logic                               wready_q, wready_d;
   logic                               bvalid_q, bvalid_d;
   logic                               arready_q, arready_d;
   logic                               rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q, rdata_d;

   logic                               aw_hs, w_hs, ar_hs, commit;
   logic [1:0]                         wr_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]      wr_data;
   logic [NumBytes-1:0]                wr_strb;

   // Protection bits and the byte offset within a word carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0]};

   always_comb begin
      aw_hs   = s00_axi_awvalid && awready_q;
      w_hs    = s00_axi_wvalid && wready_q;
      ar_hs   = s00_axi_arvalid && arready_q;
      wr_idx  = aw_held_q ? aw_idx_q : s00_axi_awaddr[3:2];
      wr_data = w_held_q ? w_data_q : s00_axi_wdata;
      wr_strb = w_held_q ? w_strb_q : s00_axi_wstrb;
      commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;

      aw_held_d = aw_held_q;
      aw_idx_d  = aw_idx_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      regs_d    = regs_q;
      pulse_d   = '0;

      if (commit) begin
         aw_held_d       = 1'b0;
         w_held_d        = 1'b0;
         pulse_d[wr_idx] = 1'b1;
         for (int k = 0; k < NumBytes; k++) begin
            if (wr_strb[k]) regs_d[wr_idx][8*k +: 8] = wr_data[8*k +: 8];
         end
      end else begin
         if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[3:2];
         end
         if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
         end
      end

      if (commit)                          bvalid_d = 1'b1;
      else if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
      else                                 bvalid_d = bvalid_q;

      awready_d = !aw_held_d && !bvalid_d;
      wready_d  = !w_held_d && !bvalid_d;

      // Read data captures the pre-commit value when a write to the same word lands this cycle.
      rdata_d = rdata_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[s00_axi_araddr[3:2]];
      end else if (rvalid_q && s00_axi_rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
      arready_d = !rvalid_d;
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         regs_q    <= '0;
         pulse_q   <= '0;
         aw_held_q <= 1'b0;
         aw_idx_q  <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         pulse_q   <= pulse_d;
         aw_held_q <= aw_held_d;
         aw_idx_q  <= aw_idx_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = wready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = 2'b00;
   assign slv_reg0        = regs_q[0];
   assign slv_reg1        = regs_q[1];
   assign slv_reg2        = regs_q[2];
   assign slv_reg3        = regs_q[3];
   assign reg_wr_pulse    = pulse_q;

endmodule

// File: tb/tb_axi_cro_s00_axi_slave.sv
// Self-checking bench for axi_cro_s00_axi_slave: directed scenarios plus random traffic
// against a word-array register model.
module tb_axi_cro_s00_axi_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata, slv_reg0, slv_reg1, slv_reg2, slv_reg3;
   logic [3:0]  reg_wr_pulse;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] model [4];
   logic [31:0] rd, rd2;

   always #5 clk = ~clk;

   axi_cro_s00_axi_slave dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .slv_reg0        (slv_reg0),
      .slv_reg1        (slv_reg1),
      .slv_reg2        (slv_reg2),
      .slv_reg3        (slv_reg3),
      .reg_wr_pulse    (reg_wr_pulse)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dut_reg(input logic [1:0] i);
      case (i)
         2'd0:    return slv_reg0;
         2'd1:    return slv_reg1;
         2'd2:    return slv_reg2;
         default: return slv_reg3;
      endcase
   endfunction

   // Independent AW/W launch; returns one cycle after the B handshake.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      logic [3:0] exp_pulse;
      fork
         begin
            repeat (aw_dly) step();
            awaddr  = addr;
            awvalid = 1'b1;
            for (int n = 0; n < 50 && !awready; n++) step();
            check("aw_ready", 32'(awready), 32'd1);
            step();
            awvalid = 1'b0;
         end
         begin
            repeat (w_dly) step();
            wdata  = data;
            wstrb  = strb;
            wvalid = 1'b1;
            for (int n = 0; n < 50 && !wready; n++) step();
            check("w_ready", 32'(wready), 32'd1);
            step();
            wvalid = 1'b0;
         end
      join
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) model[addr[3:2]][8*k +: 8] = data[8*k +: 8];
      end
      exp_pulse = 4'b0001 << addr[3:2];
      check("b_valid_next_cycle", 32'(bvalid), 32'd1);
      check("b_resp", 32'(bresp), 32'd0);
      check("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
      check("slv_reg_after_write", dut_reg(addr[3:2]), model[addr[3:2]]);
      for (int i = 0; i < b_dly; i++) begin
         step();
         check("b_hold_valid", 32'(bvalid), 32'd1);
         check("b_hold_awready", 32'(awready), 32'd0);
         check("b_hold_wready", 32'(wready), 32'd0);
         if (i == 0) check("wr_pulse_one_cycle", 32'(reg_wr_pulse), 32'd0);
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("b_done", 32'(bvalid), 32'd0);
      check("wr_pulse_clear", 32'(reg_wr_pulse), 32'd0);
      check("aw_ready_after_b", 32'(awready), 32'd1);
   endtask

   task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
      araddr  = addr;
      arvalid = 1'b1;
      for (int n = 0; n < 50 && !arready; n++) step();
      check("ar_ready", 32'(arready), 32'd1);
      step();
      arvalid = 1'b0;
      check("r_valid", 32'(rvalid), 32'd1);
      check("r_resp", 32'(rresp), 32'd0);
      data = rdata;
      for (int i = 0; i < r_dly; i++) begin
         step();
         check("r_hold_valid", 32'(rvalid), 32'd1);
         check("r_hold_data", rdata, data);
         check("r_hold_arready", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("r_done", 32'(rvalid), 32'd0);
      check("ar_ready_after_r", 32'(arready), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) model[i] = '0;

      // Reset state
      repeat (3) step();
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_resp", 32'({bresp, rresp}), 32'd0);
      check("rst_slv_reg0", slv_reg0, 32'd0);
      check("rst_slv_reg3", slv_reg3, 32'd0);
      check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
      rst_n = 1'b1;
      step();
      check("rel_awready", 32'(awready), 32'd1);
      check("rel_wready", 32'(wready), 32'd1);
      check("rel_arready", 32'(arready), 32'd1);

      // Sequential writes and read-back
      for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), 0, rd);
         check("seq_readback", rd, 32'(i + 1));
      end

      // W three cycles ahead of AW
      wdata  = 32'hDEADBEEF;
      wstrb  = 4'hF;
      wvalid = 1'b1;
      check("wfirst_wready", 32'(wready), 32'd1);
      step();
      wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("wfirst_wready_low", 32'(wready), 32'd0);
         check("wfirst_no_bvalid", 32'(bvalid), 32'd0);
         step();
      end
      awaddr  = 4'h8;
      awvalid = 1'b1;
      check("wfirst_awready", 32'(awready), 32'd1);
      step();
      awvalid  = 1'b0;
      model[2] = 32'hDEADBEEF;
      check("wfirst_bvalid", 32'(bvalid), 32'd1);
      check("wfirst_pulse", 32'(reg_wr_pulse), 32'h4);
      check("wfirst_slv_reg2", slv_reg2, 32'hDEADBEEF);
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("wfirst_pulse_clear", 32'(reg_wr_pulse), 32'd0);
      check("wfirst_b_done", 32'(bvalid), 32'd0);

      // Byte strobes, including an all-zero strobe
      axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axi_write(4'h4, 32'h12345678, 4'b0101, 1, 0, 0);
      axi_read(4'h4, 0, rd);
      check("strb_readback", rd, 32'hFF34FF78);
      axi_write(4'h5, 32'h0BADF00D, 4'b0000, 0, 2, 0);
      axi_read(4'h7, 0, rd);
      check("strb_zero_readback", rd, 32'hFF34FF78);

      // Backpressure on B and R
      axi_write(4'hC, 32'h00000077, 4'hF, 0, 0, 10);
      axi_read(4'hC, 5, rd);
      check("bp_readback", rd, 32'h00000077);

      // Same-cycle read and write of word 0
      axi_write(4'h0, 32'hA, 4'hF, 0, 0, 0);
      fork
         axi_write(4'h0, 32'hB, 4'hF, 0, 0, 0);
         axi_read(4'h0, 0, rd);
      join
      check("same_cycle_old", rd, 32'hA);
      axi_read(4'h0, 0, rd);
      check("same_cycle_new", rd, 32'hB);

      // Random traffic with unaligned addresses against the model
      for (int i = 0; i < 24; i++) begin
         logic [3:0] a, ra;
         a  = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
         axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2));
         axi_read(ra, $urandom_range(0, 2), rd);
         check("rand_readback", rd, model[ra[3:2]]);
      end

      // Reset while a write response is pending
      awaddr  = 4'hC;
      awvalid = 1'b1;
      wdata   = 32'h55;
      wstrb   = 4'hF;
      wvalid  = 1'b1;
      step();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("mid_pre_bvalid", 32'(bvalid), 32'd1);
      check("mid_pre_slv_reg3", slv_reg3, 32'h55);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) model[i] = '0;
      check("mid_bvalid", 32'(bvalid), 32'd0);
      check("mid_slv_reg3", slv_reg3, 32'd0);
      check("mid_awready", 32'(awready), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("mid_rel_awready", 32'(awready), 32'd1);
      check("mid_rel_wready", 32'(wready), 32'd1);
      check("mid_rel_arready", 32'(arready), 32'd1);
      axi_write(4'h8, 32'hCAFE0001, 4'hF, 0, 0, 0);
      axi_read(4'h8, 0, rd);
      check("mid_after_write", rd, 32'hCAFE0001);
      axi_read(4'hC, 0, rd2);
      check("mid_reg3_cleared", rd2, model[3]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
